// File: rtl/mc_controller_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_controller_hs: multicycle MIPS control FSM with memory handshake, |
// | immediate ALU ops, bne/j and illegal-instruction trap. Revision 1.0  |
// +----------------------------------------------------------------------+
module mc_controller_hs #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit IMM_LOGIC     = 1'b1,
  parameter bit TRAP_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       immzext,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t     state_q, state_d, bad_d;
  logic       ready;
  logic       funct_ok;
  logic       imm_ok;
  logic       imm_zx;
  logic [2:0] funct_alu;
  logic [2:0] imm_alu;

  // Instruction field decode, independent of the current state.
  always_comb begin
    ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    if (TRAP_EN) bad_d = S_TRAP;
    else         bad_d = S_FETCH;

    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      F_ADD:   funct_alu = 3'b010;
      F_SUB:   funct_alu = 3'b110;
      F_AND:   funct_alu = 3'b000;
      F_OR:    funct_alu = 3'b001;
      F_SLT:   funct_alu = 3'b111;
      default: funct_ok  = 1'b0;
    endcase

    imm_ok  = 1'b1;
    imm_alu = 3'b010;
    imm_zx  = 1'b0;
    case (op)
      OP_ADDI: imm_alu = 3'b010;
      OP_ANDI: begin imm_ok = IMM_LOGIC; imm_alu = 3'b000; imm_zx = 1'b1; end
      OP_ORI:  begin imm_ok = IMM_LOGIC; imm_alu = 3'b001; imm_zx = 1'b1; end
      OP_SLTI: begin imm_ok = IMM_LOGIC; imm_alu = 3'b111; end
      default: imm_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    immzext    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    illegal    = 1'b0;
    state      = state_q;

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = ready;
        pcen    = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = funct_ok ? S_RTEX : bad_d;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = imm_ok ? S_IMMEX : bad_d;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_RTEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = S_RTWB;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IMMEX, S_IMMWB: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = imm_alu;
        immzext    = imm_zx;
        regwrite   = (state_q == S_IMMWB);
        state_d    = (state_q == S_IMMEX) ? S_IMMWB : S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = (op == OP_BEQ) ? zero : ~zero;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Side-effecting strobes must be quiet for the whole reset window.
    if (!reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_controller_hs: bench for mc_controller_hs in four parameter    |
// | variants sharing one stimulus bus. Revision 1.0                      |
// +----------------------------------------------------------------------+
module tb_mc_controller_hs;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pcen_a [4], irwrite_a [4], regwrite_a [4], memread_a [4], memwrite_a [4];
  logic       iord_a [4], alusrca_a [4], immzext_a [4], regdst_a [4], memtoreg_a [4];
  logic       illegal_a [4];
  logic [1:0] alusrcb_a [4], pcsrc_a [4];
  logic [2:0] alucontrol_a [4];
  logic [3:0] state_a [4];

  int errors = 0;
  int checks = 0;

  logic [5:0] op_tab [10] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J};
  logic [5:0] fn_tab [5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  // Observations of one instruction, FETCH up to the next FETCH.
  int         o_cycles, o_irw, o_rw, o_pcen, o_mrd, o_mwr;
  bit         o_trap, o_timeout, o_has_ex;
  logic [2:0] o_alu;
  logic       o_zx, o_dst, o_m2r;
  logic [1:0] o_expc, o_lastpc;

  // Reference expectations.
  int         e_cycles, e_irw, e_rw, e_pcen, e_mrd, e_mwr;
  bit         e_trap, e_has_ex;
  logic [2:0] e_alu;
  logic       e_zx, e_dst, e_m2r;
  logic [1:0] e_expc, e_lastpc;

  always #5 clk = ~clk;

  // DUT 0: all features, 1: IMM_LOGIC=0, 2: TRAP_EN=0, 3: MEM_HANDSHAKE=0
  for (genvar k = 0; k < 4; k++) begin : g_dut
    mc_controller_hs #(
      .MEM_HANDSHAKE(k != 3),
      .IMM_LOGIC    (k != 1),
      .TRAP_EN      (k != 2)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .funct     (funct),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pcen      (pcen_a[k]),
      .irwrite   (irwrite_a[k]),
      .regwrite  (regwrite_a[k]),
      .memread   (memread_a[k]),
      .memwrite  (memwrite_a[k]),
      .iord      (iord_a[k]),
      .alusrca   (alusrca_a[k]),
      .alusrcb   (alusrcb_a[k]),
      .immzext   (immzext_a[k]),
      .regdst    (regdst_a[k]),
      .memtoreg  (memtoreg_a[k]),
      .pcsrc     (pcsrc_a[k]),
      .alucontrol(alucontrol_a[k]),
      .illegal   (illegal_a[k]),
      .state     (state_a[k])
    );
  end

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Runs one instruction on DUT k starting at posedge+1 of its FETCH cycle.
  // wf/wm: mem_ready-low cycles for the fetch and the data access.
  task automatic run_instr(input int k, input logic [5:0] i_op, input logic [5:0] i_funct,
                           input logic i_zero, input int wf, input int wm, input bit ready_low);
    int fw, dw;
    bit prev_fetch, fetch_now;
    fw = wf; dw = wm; prev_fetch = 1'b1;
    o_cycles = 0; o_irw = 0; o_rw = 0; o_pcen = 0; o_mrd = 0; o_mwr = 0;
    o_trap = 1'b0; o_timeout = 1'b0; o_has_ex = 1'b0;
    o_alu = 3'b000; o_zx = 1'b0; o_dst = 1'b0; o_m2r = 1'b0; o_expc = 2'b00; o_lastpc = 2'b00;
    op = i_op; funct = i_funct; zero = i_zero;
    for (int c = 0; c < 40; c++) begin
      #1;
      fetch_now = memread_a[k] && !iord_a[k];
      if (c > 0 && fetch_now && !prev_fetch) return;
      if (ready_low) mem_ready = 1'b0;
      else if (fetch_now) begin
        mem_ready = (fw == 0);
        if (fw > 0) fw--;
      end else if (memread_a[k] || memwrite_a[k]) begin
        mem_ready = (dw == 0);
        if (dw > 0) dw--;
      end else mem_ready = 1'($urandom);
      #1;
      if (illegal_a[k]) begin
        o_trap = 1'b1;
        return;
      end
      o_cycles++;
      o_irw  += int'(irwrite_a[k]);
      o_pcen += int'(pcen_a[k]);
      o_mrd  += int'(memread_a[k]);
      o_mwr  += int'(memwrite_a[k]);
      if (regwrite_a[k]) begin
        o_rw++;
        o_dst = regdst_a[k];
        o_m2r = memtoreg_a[k];
      end
      if (alusrca_a[k] && !regwrite_a[k]) begin
        o_has_ex = 1'b1;
        o_alu  = alucontrol_a[k];
        o_zx   = immzext_a[k];
        o_expc = pcsrc_a[k];
      end
      if (pcen_a[k] && !fetch_now) o_lastpc = pcsrc_a[k];
      prev_fetch = fetch_now;
      @(posedge clk);
      #1;
    end
    o_timeout = 1'b1;
  endtask

  // Per-instruction outcome derived from the instruction class table.
  task automatic model(input int k, input logic [5:0] m_op, input logic [5:0] m_funct,
                       input logic m_zero, input int wf, input int wm);
    bit hs, imml, trp, taken;
    int ewf, ewm;
    hs = (k != 3); imml = (k != 1); trp = (k != 2);
    ewf = hs ? wf : 0;
    ewm = hs ? wm : 0;
    e_irw = 1; e_pcen = 1; e_rw = 0; e_mrd = 1 + ewf; e_mwr = 0;
    e_trap = 1'b0; e_has_ex = 1'b0; e_alu = 3'b010; e_zx = 1'b0;
    e_dst = 1'b0; e_m2r = 1'b0; e_expc = 2'b00; e_lastpc = 2'b00;
    e_cycles = 2 + ewf;
    case (m_op)
      OP_LW: begin
        e_cycles = 5 + ewf + ewm; e_mrd += 1 + ewm; e_rw = 1; e_m2r = 1'b1; e_has_ex = 1'b1;
      end
      OP_SW: begin
        e_cycles = 4 + ewf + ewm; e_mwr = 1 + ewm; e_has_ex = 1'b1;
      end
      OP_R: begin
        e_cycles = 4 + ewf; e_rw = 1; e_dst = 1'b1; e_has_ex = 1'b1;
        case (m_funct)
          6'b100000: e_alu = 3'b010;
          6'b100010: e_alu = 3'b110;
          6'b100100: e_alu = 3'b000;
          6'b100101: e_alu = 3'b001;
          6'b101010: e_alu = 3'b111;
          default: begin
            e_cycles = 2 + ewf; e_rw = 0; e_dst = 1'b0; e_has_ex = 1'b0; e_trap = trp;
          end
        endcase
      end
      OP_BEQ, OP_BNE: begin
        taken = (m_op == OP_BEQ) ? m_zero : !m_zero;
        e_cycles = 3 + ewf; e_pcen = 1 + int'(taken);
        e_has_ex = 1'b1; e_alu = 3'b110; e_expc = 2'b01; e_lastpc = 2'b01;
      end
      OP_J: begin
        e_cycles = 3 + ewf; e_pcen = 2; e_lastpc = 2'b10;
      end
      OP_ADDI: begin
        e_cycles = 4 + ewf; e_rw = 1; e_has_ex = 1'b1; e_alu = 3'b010;
      end
      OP_ANDI, OP_ORI, OP_SLTI: begin
        if (imml) begin
          e_cycles = 4 + ewf; e_rw = 1; e_has_ex = 1'b1;
          e_alu = (m_op == OP_ANDI) ? 3'b000 : (m_op == OP_ORI) ? 3'b001 : 3'b111;
          e_zx  = (m_op != OP_SLTI);
        end else e_trap = trp;
      end
      default: e_trap = trp;
    endcase
  endtask

  task automatic test_reset();
    op = OP_LW; mem_ready = 1'b1; reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #3;
      checks++;
      if ({pcen_a[0], irwrite_a[0], regwrite_a[0], memread_a[0], memwrite_a[0]} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_writes cyc=%0d actual=%b expected=00000", c,
                 {pcen_a[0], irwrite_a[0], regwrite_a[0], memread_a[0], memwrite_a[0]});
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({memread_a[0], irwrite_a[0], pcen_a[0], iord_a[0], alusrcb_a[0]} !== 6'b111001) begin
      errors++;
      $display("FAIL reset_first_fetch actual=%b expected=111001",
               {memread_a[0], irwrite_a[0], pcen_a[0], iord_a[0], alusrcb_a[0]});
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    run_instr(0, OP_LW, 6'd0, 1'b0, 2, 2, 1'b0);
    checks++;
    if (o_cycles !== 9 || o_timeout) begin
      errors++; $display("FAIL lw_wait_cycles actual=%0d expected=9", o_cycles);
    end
    checks++;
    if ({o_irw, o_rw, o_mrd} !== {32'd1, 32'd1, 32'd6}) begin
      errors++; $display("FAIL lw_wait_pulses irw/rw/mrd actual=%0d/%0d/%0d expected=1/1/6", o_irw, o_rw, o_mrd);
    end
    checks++;
    if ({o_m2r, o_dst} !== 2'b10) begin
      errors++; $display("FAIL lw_wb memtoreg/regdst actual=%b expected=10", {o_m2r, o_dst});
    end
    // abort a stalled fetch with reset
    op = OP_LW; mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({memread_a[0], irwrite_a[0], pcen_a[0]} !== 3'b000) begin
      errors++; $display("FAIL midwait_reset actual=%b expected=000", {memread_a[0], irwrite_a[0], pcen_a[0]});
    end
    @(posedge clk);
    #1 reset = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if ({memread_a[0], iord_a[0], irwrite_a[0]} !== 3'b101) begin
      errors++; $display("FAIL midwait_refetch actual=%b expected=101", {memread_a[0], iord_a[0], irwrite_a[0]});
    end
  endtask

  task automatic test_branch();
    logic [5:0] bop [4] = '{OP_BNE, OP_BEQ, OP_BNE, OP_BEQ};
    logic       bz  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int         bpc [4] = '{2, 1, 1, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_instr(0, bop[i], 6'd0, bz[i], 0, 0, 1'b0);
      checks++;
      if (o_cycles !== 3 || o_pcen !== bpc[i] || o_expc !== 2'b01 || o_alu !== 3'b110) begin
        errors++;
        $display("FAIL branch op=%b z=%b cyc/pcen/pcsrc/alu actual=%0d/%0d/%b/%b expected=3/%0d/01/110",
                 bop[i], bz[i], o_cycles, o_pcen, o_expc, o_alu, bpc[i]);
      end
    end
  endtask

  task automatic test_ori();
    do_reset();
    run_instr(0, OP_ORI, 6'd0, 1'b0, 0, 0, 1'b0);
    checks++;
    if ({o_alu, o_zx} !== 4'b0011 || o_cycles !== 4) begin
      errors++; $display("FAIL ori_ex alu/zx/cyc actual=%b/%b/%0d expected=001/1/4", o_alu, o_zx, o_cycles);
    end
    checks++;
    if (o_rw !== 1 || o_dst !== 1'b0) begin
      errors++; $display("FAIL ori_wb rw/regdst actual=%0d/%b expected=1/0", o_rw, o_dst);
    end
    do_reset();
    run_instr(1, OP_ORI, 6'd0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_trap !== 1'b1) begin
      errors++; $display("FAIL ori_noimm_illegal actual=%b expected=1", o_trap);
    end
  endtask

  task automatic test_trap();
    do_reset();
    run_instr(0, OP_R, 6'b000000, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_trap !== 1'b1 || o_rw !== 0) begin
      errors++; $display("FAIL trap_enter trap/rw actual=%b/%0d expected=1/0", o_trap, o_rw);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      mem_ready = 1'($urandom);
      #2;
      checks++;
      if ({illegal_a[0], pcen_a[0], irwrite_a[0], regwrite_a[0], memread_a[0], memwrite_a[0]} !== 6'b100000) begin
        errors++;
        $display("FAIL trap_hold cyc=%0d actual=%b expected=100000", c,
                 {illegal_a[0], pcen_a[0], irwrite_a[0], regwrite_a[0], memread_a[0], memwrite_a[0]});
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (illegal_a[0] !== 1'b0) begin
      errors++; $display("FAIL trap_reset illegal actual=%b expected=0", illegal_a[0]);
    end
    @(posedge clk);
    #1 reset = 1'b1; mem_ready = 1'b1;
    run_instr(2, OP_R, 6'b000000, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_trap !== 1'b0 || o_cycles !== 2 || o_rw !== 0) begin
      errors++; $display("FAIL trap_off_nop trap/cyc/rw actual=%b/%0d/%0d expected=0/2/0", o_trap, o_cycles, o_rw);
    end
  endtask

  task automatic test_jump_nohs();
    do_reset();
    run_instr(0, OP_J, 6'd0, 1'b0, 0, 0, 1'b0);
    checks++;
    if (o_cycles !== 3 || o_pcen !== 2 || o_lastpc !== 2'b10) begin
      errors++; $display("FAIL jump cyc/pcen/pcsrc actual=%0d/%0d/%b expected=3/2/10", o_cycles, o_pcen, o_lastpc);
    end
    do_reset();
    run_instr(3, OP_SW, 6'd0, 1'b0, 0, 0, 1'b1);
    checks++;
    if (o_cycles !== 4 || o_mwr !== 1 || o_timeout) begin
      errors++; $display("FAIL nohs_sw cyc/mwr actual=%0d/%0d expected=4/1", o_cycles, o_mwr);
    end
  endtask

  task automatic test_back_to_back();
    int k, wf, wm, idx;
    logic [5:0] r_op, r_fn;
    logic r_z;
    for (int n = 0; n < 80; n++) begin
      k = n / 20;
      if (n % 20 == 0) do_reset();
      idx  = $urandom_range(0, 10);
      r_op = (idx == 10) ? 6'($urandom) : op_tab[idx];
      r_fn = ($urandom_range(0, 1) == 1) ? fn_tab[$urandom_range(0, 4)] : 6'($urandom);
      r_z  = 1'($urandom);
      wf   = $urandom_range(0, 2);
      wm   = $urandom_range(0, 2);
      run_instr(k, r_op, r_fn, r_z, wf, wm, 1'b0);
      model(k, r_op, r_fn, r_z, wf, wm);
      checks++;
      if (o_timeout || o_trap !== e_trap || o_cycles !== e_cycles) begin
        errors++;
        $display("FAIL rand_flow k=%0d op=%b fn=%b to/trap/cyc actual=%b/%b/%0d expected=0/%b/%0d",
                 k, r_op, r_fn, o_timeout, o_trap, o_cycles, e_trap, e_cycles);
      end
      checks++;
      if ({o_irw, o_pcen, o_rw, o_mrd, o_mwr} !== {e_irw, e_pcen, e_rw, e_mrd, e_mwr}) begin
        errors++;
        $display("FAIL rand_counts k=%0d op=%b irw/pcen/rw/mrd/mwr actual=%0d/%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d/%0d",
                 k, r_op, o_irw, o_pcen, o_rw, o_mrd, o_mwr, e_irw, e_pcen, e_rw, e_mrd, e_mwr);
      end
      if (e_rw == 1) begin
        checks++;
        if ({o_dst, o_m2r} !== {e_dst, e_m2r}) begin
          errors++; $display("FAIL rand_wb k=%0d op=%b actual=%b expected=%b", k, r_op, {o_dst, o_m2r}, {e_dst, e_m2r});
        end
      end
      if (e_has_ex) begin
        checks++;
        if ({o_has_ex, o_alu, o_zx, o_expc} !== {1'b1, e_alu, e_zx, e_expc}) begin
          errors++;
          $display("FAIL rand_ex k=%0d op=%b fn=%b actual=%b expected=%b", k, r_op, r_fn,
                   {o_has_ex, o_alu, o_zx, o_expc}, {1'b1, e_alu, e_zx, e_expc});
        end
      end
      if (e_pcen == 2) begin
        checks++;
        if (o_lastpc !== e_lastpc) begin
          errors++; $display("FAIL rand_pcsrc k=%0d op=%b actual=%b expected=%b", k, r_op, o_lastpc, e_lastpc);
        end
      end
      if (o_trap || o_timeout) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_branch();
    test_ori();
    test_trap();
    test_jump_nohs();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
